stopwatch_counter: RTL

- Time-keeping stage directly upstream of the multiplexed display driver.
- Holds the mm:ss stopwatch value as four BCD digits and handles run/pause and the adjust mode.
- Emits four registered 7-segment cathode patterns. The display driver consumes them together with the same adj/sel levels.
- Timing comes from single-cycle enable pulses generated by the clock divider. The block has no derived clocks.

---
 rtl/stopwatch_counter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/stopwatch_counter.sv
// mm:ss stopwatch: four BCD digits, RUN/PAUSED control, adjust mode and registered 7-segment cathodes.
// Optional: define STOPWATCH_LEADING_BLANK_EN to blank the minutes-tens cathode while that digit is zero.
module stopwatch_counter #(
    parameter int unsigned MAX_MINUTES    = 59,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       pause_pulse,
    input  logic       clr,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] minutes_tens_bcd,
    output logic [3:0] minutes_ones_bcd,
    output logic [3:0] seconds_tens_bcd,
    output logic [3:0] seconds_ones_bcd,
    output logic [6:0] minutes_tens_cathode,
    output logic [6:0] minutes_ones_cathode,
    output logic [6:0] seconds_tens_cathode,
    output logic [6:0] seconds_ones_cathode,
    output logic       paused
);

    localparam logic [3:0] MAX_MT  = 4'(MAX_MINUTES / 10);
    localparam logic [3:0] MAX_MO  = 4'(MAX_MINUTES % 10);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;

    typedef enum logic {
        ST_PAUSED = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    // Lit-segment table is kept active-high and flipped once for board polarity.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] lit;
        case (d)
            4'd0:    lit = 7'b0111111;
            4'd1:    lit = 7'b0000110;
            4'd2:    lit = 7'b1011011;
            4'd3:    lit = 7'b1001111;
            4'd4:    lit = 7'b1100110;
            4'd5:    lit = 7'b1101101;
            4'd6:    lit = 7'b1111101;
            4'd7:    lit = 7'b0000111;
            4'd8:    lit = 7'b1111111;
            4'd9:    lit = 7'b1101111;
            default: lit = 7'b0000000;
        endcase
        return SEG_ACTIVE_LOW ? ~lit : lit;
    endfunction

`ifdef STOPWATCH_LEADING_BLANK_EN
    localparam logic [6:0] MT_CATH_RST = SEG_OFF;
`else
    localparam logic [6:0] MT_CATH_RST = seg_decode(4'd0);
`endif

    state_t     state_q, state_d;
    logic [3:0] mt_q, mo_q, st_q, so_q;
    logic [3:0] mt_d, mo_d, st_d, so_d;
    logic [3:0] mt_inc, mo_inc, st_inc, so_inc;
    logic       sec_wrap, min_wrap;
    logic [6:0] mt_cath_q, mo_cath_q, st_cath_q, so_cath_q;
    logic [6:0] mt_cath_d;

    assign sec_wrap = (st_q == 4'd5) && (so_q == 4'd9);
    assign min_wrap = (mt_q == MAX_MT) && (mo_q == MAX_MO);

    always_comb begin
        so_inc = (so_q == 4'd9) ? 4'd0 : so_q + 4'd1;
        st_inc = st_q;
        if (sec_wrap) begin
            st_inc = 4'd0;
        end else if (so_q == 4'd9) begin
            st_inc = st_q + 4'd1;
        end
        mo_inc = (min_wrap || mo_q == 4'd9) ? 4'd0 : mo_q + 4'd1;
        mt_inc = mt_q;
        if (min_wrap) begin
            mt_inc = 4'd0;
        end else if (mo_q == 4'd9) begin
            mt_inc = mt_q + 4'd1;
        end
    end

    // Count decision uses state_q, so a same-cycle toggle only affects later ticks.
    always_comb begin
        state_d = state_q;
        mt_d    = mt_q;
        mo_d    = mo_q;
        st_d    = st_q;
        so_d    = so_q;
        if (pause_pulse && !adj) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
        end
        if (clr) begin
            mt_d = 4'd0;
            mo_d = 4'd0;
            st_d = 4'd0;
            so_d = 4'd0;
        end else if (adj) begin
            if (tick_2hz) begin
                if (sel) begin
                    st_d = st_inc;
                    so_d = so_inc;
                end else begin
                    mt_d = mt_inc;
                    mo_d = mo_inc;
                end
            end
        end else if (state_q == ST_RUN && tick_1hz) begin
            st_d = st_inc;
            so_d = so_inc;
            if (sec_wrap) begin
                mt_d = mt_inc;
                mo_d = mo_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_PAUSED;
            mt_q    <= 4'd0;
            mo_q    <= 4'd0;
            st_q    <= 4'd0;
            so_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            mt_q    <= mt_d;
            mo_q    <= mo_d;
            st_q    <= st_d;
            so_q    <= so_d;
        end
    end

`ifdef STOPWATCH_LEADING_BLANK_EN
    assign mt_cath_d = (mt_q == 4'd0) ? SEG_OFF : seg_decode(mt_q);
`else
    assign mt_cath_d = seg_decode(mt_q);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mt_cath_q <= MT_CATH_RST;
            mo_cath_q <= seg_decode(4'd0);
            st_cath_q <= seg_decode(4'd0);
            so_cath_q <= seg_decode(4'd0);
        end else begin
            mt_cath_q <= mt_cath_d;
            mo_cath_q <= seg_decode(mo_q);
            st_cath_q <= seg_decode(st_q);
            so_cath_q <= seg_decode(so_q);
        end
    end

    assign minutes_tens_bcd     = mt_q;
    assign minutes_ones_bcd     = mo_q;
    assign seconds_tens_bcd     = st_q;
    assign seconds_ones_bcd     = so_q;
    assign minutes_tens_cathode = mt_cath_q;
    assign minutes_ones_cathode = mo_cath_q;
    assign seconds_tens_cathode = st_cath_q;
    assign seconds_ones_cathode = so_cath_q;
    assign paused               = (state_q == ST_PAUSED);

endmodule
